// File: rtl/booth4_pkg.sv
`default_nettype none
// ============================================================================
// Module  : booth4_pkg
// Purpose : Shared types for the radix-4 Booth multiplier controller:
//           FSM state encoding, recoded-digit struct and default operand width.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package booth4_pkg;

    // Default operand width; must be even and >= 4.
    localparam int unsigned BOOTH4_N_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        LOAD_M = 3'd2,
        SCAN   = 3'd3,
        SHIFT  = 3'd4,
        OUT_HI = 3'd5,
        OUT_LO = 3'd6,
        DONE   = 3'd7
    } booth4_state_t;

    // Recoded Booth digit in sign/magnitude form:
    //   nz  - digit is non-zero (an add/subtract is needed)
    //   dbl - magnitude is 2 (use 2M instead of M)
    //   neg - digit is negative (subtract)
    typedef struct packed {
        logic nz;
        logic dbl;
        logic neg;
    } booth4_digit_t;

endpackage
`default_nettype wire

// File: rtl/booth4_if.sv
`default_nettype none
// ============================================================================
// Module  : booth4_if
// Purpose : Control/handshake bundle between the Booth controller and its
//           host + datapath.
// Signals : start        host request, sampled only while idle
//           q_bits[2:0]  {Q[1],Q[0],Q[-1]} recode window from the Q register
//           abort        (BOOTH4_ABORT_EN only) cancel the running operation
//           c0..c7       datapath control strobes
//           busy, done   host status
// Modports: master - host/datapath side; slave - controller side
// Config  : BOOTH4_ABORT_EN adds the abort signal
// Revision: 1.0 - initial release
// ============================================================================
interface booth4_if;
    logic       start;
    logic [2:0] q_bits;
`ifdef BOOTH4_ABORT_EN
    logic       abort;
`endif
    logic       c0;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;
    logic       c5;
    logic       c6;
    logic       c7;
    logic       busy;
    logic       done;

    modport master (
`ifdef BOOTH4_ABORT_EN
        output abort,
`endif
        output start, q_bits,
        input  c0, c1, c2, c3, c4, c5, c6, c7, busy, done
    );

    modport slave (
`ifdef BOOTH4_ABORT_EN
        input  abort,
`endif
        input  start, q_bits,
        output c0, c1, c2, c3, c4, c5, c6, c7, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/booth4_recoder.sv
`default_nettype none
// ============================================================================
// Module  : booth4_recoder
// Purpose : Combinational radix-4 Booth recoder. Maps the 3-bit window
//           {Q[1],Q[0],Q[-1]} to a digit in {-2,-1,0,+1,+2}.
// Ports   : q_bits[2:0] in  - recode window
//           digit       out - {nz,dbl,neg}
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module booth4_recoder
    import booth4_pkg::*;
(
    input  logic [2:0]    q_bits,
    output booth4_digit_t digit
);

    always_comb begin
        digit = '0;
        case (q_bits)
            3'b001, 3'b010: digit = '{nz: 1'b1, dbl: 1'b0, neg: 1'b0}; // +M
            3'b011:         digit = '{nz: 1'b1, dbl: 1'b1, neg: 1'b0}; // +2M
            3'b100:         digit = '{nz: 1'b1, dbl: 1'b1, neg: 1'b1}; // -2M
            3'b101, 3'b110: digit = '{nz: 1'b1, dbl: 1'b0, neg: 1'b1}; // -M
            default:        digit = '0;                                 // 000/111: 0
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/booth4_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : booth4_ctrl
// Purpose : Control FSM for a radix-4 Booth signed multiplier. Sequences
//           init, multiplicand load, ITER recode/add/shift iterations and a
//           two-beat result readout, then pulses done.
// Ports   : clk    in  - clock, rising edge
//           rst_b  in  - asynchronous active-low reset
//           bus    slave modport of booth4_if (start, q_bits, [abort],
//                  c0..c7, busy, done)
// Params  : N (operand width), ITER (= N/2 iterations), CNT_W (counter width)
// Config  : BOOTH4_ABORT_EN - honour bus.abort in any non-idle state
// Revision: 1.0 - initial release
// ============================================================================
module booth4_ctrl
    import booth4_pkg::*;
#(
    parameter int unsigned N     = BOOTH4_N_DEFAULT,
    parameter int unsigned ITER  = N / 2,
    parameter int unsigned CNT_W = $clog2(ITER + 1)
) (
    input  logic     clk,
    input  logic     rst_b,
    booth4_if.slave  bus
);

    booth4_state_t    r_state;
    booth4_state_t    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_last_iter;
    logic             w_abort;
    booth4_digit_t    w_digit;

`ifdef BOOTH4_ABORT_EN
    // Abort is meaningless while idle; masking it here keeps both the
    // next-state and output logic simple.
    assign w_abort = bus.abort && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_last_iter = (w_cnt_inc == CNT_W'(ITER));

    booth4_recoder u_recoder (
        .q_bits (bus.q_bits),
        .digit  (w_digit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Iteration counter: cleared on multiplicand load, stepped once per shift.
    // It leaves SHIFT as soon as it reaches ITER, so it never wraps.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_cnt <= '0;
        end else if (r_state == LOAD_M) begin
            r_cnt <= '0;
        end else if (r_state == SHIFT && !w_abort) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = bus.start ? INIT : IDLE;
            INIT:    w_state_nxt = LOAD_M;
            LOAD_M:  w_state_nxt = SCAN;
            SCAN:    w_state_nxt = SHIFT;
            SHIFT:   w_state_nxt = w_last_iter ? OUT_HI : SCAN;
            OUT_HI:  w_state_nxt = OUT_LO;
            OUT_LO:  w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = IDLE;
        end
    end

    // Output logic. c2/c3/c4 are Mealy on q_bits and only live in SCAN.
    always_comb begin
        bus.c0   = 1'b0;
        bus.c1   = 1'b0;
        bus.c2   = 1'b0;
        bus.c3   = 1'b0;
        bus.c4   = 1'b0;
        bus.c5   = 1'b0;
        bus.c6   = 1'b0;
        bus.c7   = 1'b0;
        bus.done = 1'b0;
        bus.busy = (r_state != IDLE);
        if (!w_abort) begin
            case (r_state)
                INIT:   bus.c0 = 1'b1;
                LOAD_M: bus.c1 = 1'b1;
                SCAN: begin
                    // dbl/neg are only meaningful with nz, so gate them to
                    // guarantee c3/c4 never appear without c2.
                    bus.c2 = w_digit.nz;
                    bus.c3 = w_digit.nz & w_digit.dbl;
                    bus.c4 = w_digit.nz & w_digit.neg;
                end
                SHIFT:  bus.c5   = 1'b1;
                OUT_HI: bus.c6   = 1'b1;
                OUT_LO: bus.c7   = 1'b1;
                DONE:   bus.done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth4_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_booth4_ctrl
// Purpose : Self-checking bench for booth4_ctrl. Drives the controller with a
//           table of recode windows and with a behavioural Booth datapath,
//           comparing every cycle's strobes against a phase model.
// Config  : BOOTH4_ABORT_EN - also exercises the abort input
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_booth4_ctrl;
    import booth4_pkg::*;

    // One recode vector: window and expected {c2,c3,c4} while in SCAN.
    typedef struct packed {
        logic [2:0] q;
        logic [2:0] exp_rec;
    } vec_t;

    localparam int C_ITER = 4;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    booth4_if bif ();

    booth4_ctrl dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bif.slave)
    );

    int         n_vec = 0;
    int         n_err = 0;
    vec_t       tbl [8];
    int         idx_sel [4];
    bit         use_dp;
    logic [9:0] sb_q [$];

    // ---------------- behavioural datapath (A:9, Q:8, Q[-1], M:9) --------
    logic [7:0]        inbus;
    logic signed [8:0] dp_a, dp_m, w_op, w_sum;
    logic [7:0]        dp_q;
    logic              dp_qm1;
    logic [16:0]       outbus;

    assign w_op   = bif.c3 ? (dp_m <<< 1) : dp_m;
    assign w_sum  = bif.c4 ? (dp_a - w_op) : (dp_a + w_op);
    assign outbus = (bif.c6 ? {dp_a, 8'h00} : 17'h0) | (bif.c7 ? {9'h000, dp_q} : 17'h0);

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            dp_a   <= '0;
            dp_m   <= '0;
            dp_q   <= '0;
            dp_qm1 <= 1'b0;
        end else begin
            if (bif.c0) begin
                dp_a   <= '0;
                dp_q   <= inbus;
                dp_qm1 <= 1'b0;
            end
            if (bif.c1) dp_m <= {inbus[7], inbus};
            if (bif.c2) dp_a <= w_sum;
            if (bif.c5) {dp_a, dp_q, dp_qm1} <= $signed({dp_a, dp_q, dp_qm1}) >>> 2;
        end
    end

    // ---------------- helpers --------------------------------------------
    function automatic logic [9:0] dut_out();
        return {bif.done, bif.busy, bif.c7, bif.c6, bif.c5, bif.c4,
                bif.c3, bif.c2, bif.c1, bif.c0};
    endfunction

    // Expected {done,busy,c7..c0} for cycle k (1 = first cycle after start).
    function automatic logic [9:0] exp_phase(input int k, input logic [2:0] rec);
        logic [9:0] e;
        e = '0;
        if (k >= 1 && k <= 13) e[8] = 1'b1;
        if (k == 1) e[0] = 1'b1;
        else if (k == 2) e[1] = 1'b1;
        else if (k >= 3 && k <= 10 && (k % 2) == 1) begin
            e[2] = rec[2];
            e[3] = rec[1];
            e[4] = rec[0];
        end
        else if (k >= 4 && k <= 10) e[5] = 1'b1;
        else if (k == 11) e[6] = 1'b1;
        else if (k == 12) e[7] = 1'b1;
        else if (k == 13) e[9] = 1'b1;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE. hold keeps start high throughout; restart_k
    // re-pulses start in that cycle; cut_k/cut_kind cut the op short with
    // reset (1) or abort (2).
    task automatic run_op(input bit hold, input int restart_k, input int cut_k, input int cut_kind);
        logic [2:0]  q;
        logic [16:0] prod;
        logic [9:0]  seen;
        int          c5_cnt;
        bit          scan;
        c5_cnt = 0;
        prod   = '0;
        bif.start = 1'b1;
        cyc();
        if (!hold) bif.start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            scan = (k >= 3 && k <= 9 && (k % 2) == 1);
            if (use_dp)    q = {dp_q[1], dp_q[0], dp_qm1};
            else if (scan) q = tbl[idx_sel[(k - 3) / 2]].q;
            else           q = 3'b011;   // non-zero window outside SCAN must be ignored
            bif.q_bits = q;
            inbus = (k == 1) ? 8'hFD : 8'h07;   // Q <= -3, M <= 7
            if (k == restart_k) bif.start = 1'b1;
            if (k == cut_k) begin
                seen = '0;
                if (cut_kind == 1) begin
                    rst_b = 1'b0;
                    #1;
                    chk("reset mid-op outputs", {22'h0, dut_out()}, 32'h0);
                    cyc();
                    cyc();
                    rst_b = 1'b1;
                end
`ifdef BOOTH4_ABORT_EN
                if (cut_kind == 2) begin
                    bif.abort = 1'b1;
                    #1;
                    chk("abort cycle strobes", {22'h0, dut_out()}, 32'h100);
                    cyc();
                    bif.abort = 1'b0;
                end
`endif
                for (int j = 0; j < 14; j++) begin
                    #1;
                    seen = seen | dut_out();
                    cyc();
                end
                chk("no activity after cut", {22'h0, seen}, 32'h0);
                return;
            end
            sb_q.push_back(exp_phase(k, scan ? tbl[q].exp_rec : 3'b000));
            #1;
            chk($sformatf("op cycle %0d", k), {22'h0, dut_out()}, {22'h0, sb_q.pop_front()});
            if (bif.c5) c5_cnt++;
            if (k == 11) prod[16:8] = outbus[16:8];
            if (k == 12) prod[7:0]  = outbus[7:0];
            cyc();
            if (!hold) bif.start = 1'b0;
        end
        chk("shift count", c5_cnt, C_ITER);
        if (use_dp) chk("product 7 x -3", {15'h0, prod}, 32'h0001_FFEB);
        #1;
        chk("idle after done", {22'h0, dut_out()}, 32'h0);
    endtask

    // ---------------- main sequence --------------------------------------
    initial begin
        tbl[0] = '{q: 3'b000, exp_rec: 3'b000};
        tbl[1] = '{q: 3'b001, exp_rec: 3'b100};
        tbl[2] = '{q: 3'b010, exp_rec: 3'b100};
        tbl[3] = '{q: 3'b011, exp_rec: 3'b110};
        tbl[4] = '{q: 3'b100, exp_rec: 3'b111};
        tbl[5] = '{q: 3'b101, exp_rec: 3'b101};
        tbl[6] = '{q: 3'b110, exp_rec: 3'b101};
        tbl[7] = '{q: 3'b111, exp_rec: 3'b000};

        use_dp     = 1'b0;
        inbus      = '0;
        rst_b      = 1'b0;
        bif.start  = 1'b0;
        bif.q_bits = 3'b000;
`ifdef BOOTH4_ABORT_EN
        bif.abort  = 1'b0;
`endif
        #1;
        chk("reset outputs", {22'h0, dut_out()}, 32'h0);
        cyc();
        cyc();
        rst_b = 1'b1;
        cyc();
        #1;
        chk("idle without start", {22'h0, dut_out()}, 32'h0);

        // All-zero digits: c2 never high, four shifts, done in cycle 13.
        idx_sel = '{0, 7, 0, 7};
        run_op(1'b0, 0, 0, 0);
        // Every recode window across two operations.
        idx_sel = '{0, 1, 2, 3};
        run_op(1'b0, 0, 0, 0);
        idx_sel = '{4, 5, 6, 7};
        run_op(1'b0, 0, 0, 0);
        // Full multiply against the datapath model.
        use_dp = 1'b1;
        run_op(1'b0, 0, 0, 0);
        use_dp = 1'b0;
        // start re-pulsed during SCAN is ignored.
        idx_sel = '{3, 4, 6, 1};
        run_op(1'b0, 5, 0, 0);
        // start held high: back-to-back ops with one idle cycle between.
        run_op(1'b1, 0, 0, 0);
        run_op(1'b0, 0, 0, 0);
        // Reset during SHIFT of iteration 2 (cycle 6).
        idx_sel = '{1, 3, 4, 6};
        run_op(1'b0, 0, 6, 1);
        cyc();
`ifdef BOOTH4_ABORT_EN
        // Abort in OUT_HI (cycle 11): no c7, no done.
        run_op(1'b0, 0, 11, 2);
        cyc();
`endif
        // Controller must still work after the cut.
        idx_sel = '{2, 5, 3, 4};
        run_op(1'b0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
